// File: rtl/regfile_dumper.sv
// Streams register-file words FIRST_REG..LAST_REG over a valid/ready port.
// Optional trailing XOR checksum word when REGFILE_DUMP_CSUM_EN is defined.
module regfile_dumper #(
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  RA,
  input  logic [31:0] RD,
  output logic [31:0] out_data,
  output logic [4:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;

  state_t     state;
  logic [4:0] idx;
  logic       hs;

`ifdef REGFILE_DUMP_CSUM_EN
  logic [31:0] checksum;
`endif

  assign hs = out_valid & out_ready;
  // The read port is only addressed while a word is being captured.
  assign RA = (state == READ) ? idx : '0;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
      checksum  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx   <= FIRST;
            busy  <= 1'b1;
            state <= READ;
`ifdef REGFILE_DUMP_CSUM_EN
            checksum <= '0;
`endif
          end
        end
        READ: begin
          out_data  <= RD;
          out_idx   <= idx;
          out_valid <= 1'b1;
`ifdef REGFILE_DUMP_CSUM_EN
          checksum  <= checksum ^ RD;
`endif
          state     <= SEND;
        end
        SEND: begin
          if (hs) begin
            if (idx < LAST) begin
              out_valid <= 1'b0;
              idx       <= idx + 5'd1;
              state     <= READ;
            end else begin
`ifdef REGFILE_DUMP_CSUM_EN
              out_data  <= checksum;
              out_idx   <= '0;
              out_valid <= 1'b1;
              state     <= CSUM;
`else
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
`endif
            end
          end
        end
        CSUM: begin
          if (hs) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Randomized bench for regfile_dumper against a queue-based word model.
// Honours REGFILE_DUMP_CSUM_EN the same way as the design build.
module tb_regfile_dumper;

  localparam int FIRST = 1;
  localparam int LAST  = 31;
  localparam int NW    = LAST - FIRST + 1;
`ifdef REGFILE_DUMP_CSUM_EN
  localparam int CSW = 1;
`else
  localparam int CSW = 0;
`endif

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } word_t;

  logic        CLK, rst, start, out_ready;
  logic [4:0]  ra, out_idx;
  logic [31:0] rd, out_data;
  logic        out_valid, busy, done;

  logic        start2, ready2;
  logic [4:0]  ra2, idx2;
  logic [31:0] rd2, data2;
  logic        valid2, busy2, done2;

  logic [31:0] regs [32];

  assign rd  = regs[ra];
  assign rd2 = regs[ra2];

  regfile_dumper #(.FIRST_REG(FIRST), .LAST_REG(LAST)) dut (
    .CLK(CLK), .rst(rst), .start(start), .RA(ra), .RD(rd),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  regfile_dumper #(.FIRST_REG(31), .LAST_REG(31)) dut_single (
    .CLK(CLK), .rst(rst), .start(start2), .RA(ra2), .RD(rd2),
    .out_data(data2), .out_idx(idx2), .out_valid(valid2),
    .out_ready(ready2), .busy(busy2), .done(done2)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state
  word_t       expq[$];
  bit          active = 0;
  bit          p_rst = 0, p_start = 0, p_ready = 0, p_valid = 0, p_done = 0, p_active = 0;
  logic [31:0] p_data = '0;
  logic [4:0]  p_idx  = '0;

  task automatic build_queue();
    logic [31:0] x;
    x = '0;
    expq.delete();
    for (int i = FIRST; i <= LAST; i++) begin
      expq.push_back('{idx: 5'(i), data: regs[i]});
      x = x ^ regs[i];
    end
`ifdef REGFILE_DUMP_CSUM_EN
    expq.push_back('{idx: 5'd0, data: x});
`endif
  endtask

  // One clock: capture driven inputs, advance, then score what the DUT did at that edge.
  task automatic tick();
    bit    fin;
    word_t w;
    p_rst   = rst;
    p_start = start;
    p_ready = out_ready;
    @(posedge CLK);
    #1;
    fin = 0;
    if (p_rst) begin
      active = 0;
      expq.delete();
    end else begin
      if (p_done) active = 0;
      if (p_start && !p_active) begin
        active = 1;
        build_queue();
      end
      if (p_valid && p_ready) begin
        if (expq.size() == 0) begin
          check("unexpected_word", 32'd1, 32'd0);
        end else begin
          w = expq.pop_front();
          check("word_idx", {27'd0, p_idx}, {27'd0, w.idx});
          check("word_data", p_data, w.data);
          if (expq.size() == 0) fin = 1;
        end
      end else if (p_valid) begin
        check("hold_valid", out_valid, 1);
        check("hold_idx", {27'd0, out_idx}, {27'd0, p_idx});
        check("hold_data", out_data, p_data);
      end
    end
    check("done", done, fin);
    check("busy", busy, active);
    p_valid  = out_valid;
    p_data   = out_data;
    p_idx    = out_idx;
    p_done   = fin;
    p_active = active;
  endtask

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // special: 0 none, 1 stall 5 cycles at idx sval, 2 reset at idx sval, 3 re-pulse start at idx sval
  task automatic run_dump(input int mode, input int special, input int sval, output int ncyc);
    int stall_left = 0;
    int ndone = 0;
    bit fired = 0;
    bit did_rst = 0;
    start = 1;
    out_ready = pick(mode);
    tick();
    start = 0;
    ncyc = 1;
    check("lat_read_valid", out_valid, 0);
    while (active && ncyc < 400) begin
      if (special == 1 && !fired && out_valid && out_idx == 5'(sval)) begin
        stall_left = 5;
        fired = 1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        check("stall_idx", {27'd0, out_idx}, sval);
        check("stall_data", out_data, regs[sval]);
        stall_left--;
      end else begin
        out_ready = pick(mode);
      end
      if (special == 2 && !fired && out_valid && out_idx == 5'(sval)) begin
        rst = 1;
        fired = 1;
        did_rst = 1;
      end
      if (special == 3 && !fired && out_valid && out_idx == 5'(sval)) begin
        start = 1;
        fired = 1;
      end
      tick();
      ncyc++;
      rst = 0;
      start = 0;
      if (ncyc == 2) begin
        check("lat_first_valid", out_valid, 1);
        check("lat_first_idx", {27'd0, out_idx}, FIRST);
      end
      if (did_rst) begin
        check("rst_data", out_data, 0);
        check("rst_idx", {27'd0, out_idx}, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        did_rst = 0;
      end
      if (done) ndone++;
    end
    check("dump_finished", {31'd0, active}, 0);
    check("done_count", ndone, (special == 2) ? 0 : 1);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    CLK = 0; rst = 1; start = 0; out_ready = 0; start2 = 0; ready2 = 1;
    for (int i = 0; i < 32; i++) regs[i] = 32'h100 + i;
    tick();
    tick();
    check("reset_data", out_data, 0);
    check("reset_idx", {27'd0, out_idx}, 0);
    check("reset_valid", out_valid, 0);
    check("reset_ra", {27'd0, ra}, 0);
    check("reset_single_valid", valid2, 0);
    rst = 0;
    tick();

    // Full dump, ready held high: one word every two cycles.
    run_dump(0, 0, 0, n);
    check("dump_cycles", n, 2 * NW + 1 + CSW + 1);
    tick();

    run_dump(0, 1, 7, n);
    tick();
    run_dump(1, 2, 12, n);
    tick();
    run_dump(0, 0, 0, n);
    run_dump(1, 3, 5, n);
    tick();

    regs[1] = 32'hFFFF0000;
    regs[2] = 32'h0000FFFF;
    run_dump(1, 0, 0, n);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      run_dump(1, 0, 0, n);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Single-register dump on the second instance.
    start2 = 1;
    tick();
    start2 = 0;
    check("single_lat_valid", valid2, 0);
    tick();
    check("single_valid", valid2, 1);
    check("single_idx", {27'd0, idx2}, 31);
    check("single_data", data2, regs[31]);
    tick();
`ifdef REGFILE_DUMP_CSUM_EN
    check("single_csum_valid", valid2, 1);
    check("single_csum_idx", {27'd0, idx2}, 0);
    check("single_csum_data", data2, regs[31]);
    tick();
`endif
    check("single_done", done2, 1);
    check("single_busy", busy2, 1);
    tick();
    check("single_done_end", done2, 0);
    check("single_busy_end", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 SHALL provide parameter FIRST_REG, default 1, first register index dumped.
REQ-002 SHALL provide parameter LAST_REG, default 31, last register index dumped; FIRST_REG <= LAST_REG <= 31 required.
REQ-003 SHALL have CLK  input  1  rising-edge clock.
REQ-004 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have RA  output  5  read address driven to a register-file read port.
REQ-007 SHALL have RD  input  32  combinational read data returned for RA.
REQ-008 SHALL have out_data  output  32  streamed word.
REQ-009 SHALL have out_idx  output  5  register index of out_data.
REQ-010 SHALL have out_valid  output  1  out_data/out_idx valid.
REQ-011 SHALL have out_ready  input  1  downstream accepts word.
REQ-012 SHALL have busy  output  1  dump in progress.
REQ-013 SHALL have done  output  1  one-cycle pulse at dump completion.

Function
REQ-014 SHALL implement states IDLE, READ, SEND, CSUM, DONE.
REQ-015 IDLE: start=1 SHALL load idx=FIRST_REG and move to READ; RA=0, busy=0.
REQ-016 READ: RA SHALL equal idx; RD SHALL be registered into out_data, idx into out_idx, out_valid set; next state SEND.
REQ-017 SEND: out_data, out_idx, out_valid SHALL stay stable until out_valid&out_ready.
REQ-018 On handshake with idx<LAST_REG: SHALL clear out_valid, increment idx, return to READ.
REQ-019 On handshake with idx==LAST_REG: SHALL go to CSUM (macro defined) or DONE (macro undefined).
REQ-020 Latency: start at cycle N SHALL give out_valid=1 at cycle N+2; with out_ready held 1, one word every 2 cycles.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in READ, SEND, CSUM, DONE.
REQ-022 start while busy=1 SHALL be ignored; no restart, no queueing.
REQ-023 idx SHALL never exceed LAST_REG; no wrap past 31.
REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-025 rst=1 at any clock edge SHALL force IDLE, idx=0, out_data=0, out_idx=0, out_valid=0, done=0, busy=0, checksum=0.
REQ-026 Reset mid-dump SHALL abort without a done pulse; next start restarts from FIRST_REG.
REQ-027 rst SHALL take priority over start and handshake in the same cycle.

Configuration
REQ-028 With REGFILE_DUMP_CSUM_EN defined: SHALL keep a 32-bit XOR of every word registered in READ, cleared at start; in CSUM SHALL present out_data=checksum, out_idx=0, out_valid=1, hold until handshake, then go to DONE.
REQ-029 Without REGFILE_DUMP_CSUM_EN: no checksum register, CSUM state unreachable, transfer count exactly LAST_REG-FIRST_REG+1.

Verification
REQ-030 Registers r1..r31 = 0x100+i, out_ready=1, start at cycle 0 -> out_valid at cycle 2, words 0x101..0x11F with idx 1..31 in order, done pulses once.
REQ-031 out_ready low for 5 cycles on r7 word -> out_data=0x107, out_idx=7 held stable all 5 cycles, no skipped or duplicated index.
REQ-032 rst asserted while out_idx=12 -> all outputs 0 next cycle, no done; later start -> first word idx 1.
REQ-033 start re-pulsed while busy at idx=5 -> ignored, sequence continues at idx 6, single done.
REQ-034 CSUM_EN, r1=0xFFFF0000, r2=0x0000FFFF, FIRST_REG=1, LAST_REG=2 -> three words: 0xFFFF0000, 0x0000FFFF, checksum 0xFFFFFFFF with out_idx=0.
REQ-035 FIRST_REG=LAST_REG=31 -> exactly one word idx 31, done at handshake cycle+1.
